// File: rtl/range_finder_mc.sv
// range_finder_mc: per-channel max/min/range/count sessions over a shared tagged sample bus, one valid/ready result port.
// Define RANGE_FINDER_SIGNED_EN to compare samples as two's complement.
module range_finder_mc #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 4,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int CNT_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    data_in,
  input  logic [CH_W-1:0]     chan,
  input  logic                sample_valid,
  input  logic                go,
  input  logic                finish,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CH_W-1:0]     res_chan,
  output logic [WIDTH-1:0]    res_max,
  output logic [WIDTH-1:0]    res_min,
  output logic [WIDTH-1:0]    res_range,
  output logic [CNT_W-1:0]    res_count,
  output logic [CHANNELS-1:0] debug_error,
  output logic                overflow
);
  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;
  state_t           st_q  [CHANNELS];
  state_t           st_d  [CHANNELS];
  logic [WIDTH-1:0] max_q [CHANNELS];
  logic [WIDTH-1:0] max_d [CHANNELS];
  logic [WIDTH-1:0] min_q [CHANNELS];
  logic [WIDTH-1:0] min_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];
  logic             samp, chan_ok, launch;
  logic [WIDTH-1:0] upd_max, upd_min;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef RANGE_FINDER_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  assign samp    = sample_valid | go | finish;
  assign chan_ok = {1'b0, chan} < (CH_W+1)'(CHANNELS);
  assign upd_max = gt(data_in, max_q[chan]) ? data_in : max_q[chan];
  assign upd_min = gt(min_q[chan], data_in) ? data_in : min_q[chan];
  assign cnt_inc = &cnt_q[chan] ? cnt_q[chan] : cnt_q[chan] + CNT_W'(1);

  always_comb begin
    st_d   = st_q;
    max_d  = max_q;
    min_d  = min_q;
    cnt_d  = cnt_q;
    launch = 1'b0;
    if (samp && chan_ok) begin
      if (go && !finish) begin
        st_d[chan]  = ACTIVE;
        max_d[chan] = data_in;
        min_d[chan] = data_in;
        cnt_d[chan] = CNT_W'(1);
      end else if (st_q[chan] != ACTIVE) begin
        st_d[chan] = finish ? ERROR : st_q[chan];
      end else if (go) begin
        st_d[chan] = ERROR;
      end else begin
        max_d[chan] = upd_max;
        min_d[chan] = upd_min;
        cnt_d[chan] = cnt_inc;
        st_d[chan]  = finish ? IDLE : ACTIVE;
        launch      = finish;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        st_q[i]  <= IDLE;
        max_q[i] <= '0;
        min_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      st_q  <= st_d;
      max_q <= max_d;
      min_q <= min_d;
      cnt_q <= cnt_d;
    end
  end

  // A launch into an unconsumed result is dropped and flagged; otherwise it loads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_chan  <= '0;
      res_max   <= '0;
      res_min   <= '0;
      res_range <= '0;
      res_count <= '0;
      overflow  <= 1'b0;
    end else if (launch && res_valid && !res_ready) begin
      overflow <= 1'b1;
    end else if (launch) begin
      res_valid <= 1'b1;
      res_chan  <= chan;
      res_max   <= upd_max;
      res_min   <= upd_min;
      res_range <= upd_max - upd_min;
      res_count <= cnt_inc;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_err
    assign debug_error[g] = st_q[g] == ERROR;
  end
endmodule

// File: tb/tb_range_finder_mc.sv
// tb_range_finder_mc: table-driven directed checks of range_finder_mc plus hand sequences for corner cases.
module tb_range_finder_mc;
`ifdef RANGE_FINDER_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;

  logic [15:0] data_in = '0;
  logic [1:0]  chan = '0;
  logic        sample_valid = 0, go = 0, finish = 0, res_ready = 0;
  logic        res_valid, overflow;
  logic [1:0]  res_chan;
  logic [15:0] res_max, res_min, res_range;
  logic [7:0]  res_count;
  logic [3:0]  debug_error;

  logic [15:0] d3 = '0;
  logic [1:0]  c3 = '0;
  logic        sv3 = 0, go3 = 0, fin3 = 0, rdy3 = 1;
  logic        v3, ovf3;
  logic [1:0]  ch3o;
  logic [15:0] max3, min3, rng3;
  logic [2:0]  cnt3, err3;

  range_finder_mc dut (
    .clock(clock), .reset(reset), .data_in(data_in), .chan(chan),
    .sample_valid(sample_valid), .go(go), .finish(finish),
    .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
    .res_max(res_max), .res_min(res_min), .res_range(res_range),
    .res_count(res_count), .debug_error(debug_error), .overflow(overflow)
  );

  range_finder_mc #(.CHANNELS(3), .CH_W(2), .CNT_W(3)) dut3 (
    .clock(clock), .reset(reset), .data_in(d3), .chan(c3),
    .sample_valid(sv3), .go(go3), .finish(fin3),
    .res_valid(v3), .res_ready(rdy3), .res_chan(ch3o),
    .res_max(max3), .res_min(min3), .res_range(rng3),
    .res_count(cnt3), .debug_error(err3), .overflow(ovf3)
  );

  typedef struct {
    logic [1:0] ch; logic sv, g, f, rdy; logic [15:0] d;
    logic ev; logic [1:0] ech; logic [15:0] emax, emin, erng; logic [7:0] ecnt;
    logic [3:0] eerr; logic eovf;
  } vec_t;
  vec_t vq[$];

  int total = 0, bad = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic drv(input logic [1:0] c, input logic s, input logic g, input logic f,
                     input logic r, input logic [15:0] d);
    chan = c; sample_valid = s; go = g; finish = f; res_ready = r; data_in = d;
    @(posedge clock);
    @(negedge clock);
    sample_valid = 0; go = 0; finish = 0;
  endtask

  task automatic drv3(input logic [1:0] c, input logic s, input logic g, input logic f, input logic [15:0] d);
    c3 = c; sv3 = s; go3 = g; fin3 = f; d3 = d;
    @(posedge clock);
    @(negedge clock);
    sv3 = 0; go3 = 0; fin3 = 0;
  endtask

  initial begin
    //               ch  sv g  f  rdy d         ev ech emax  emin  erng  ecnt err  ovf
    vq.push_back('{0, 0, 1, 0, 1, 16'h7FFF, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{0, 1, 0, 0, 1, 16'h8000, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{0, 1, 0, 0, 1, 16'h8001, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{0, 1, 0, 0, 1, 16'h7FFE, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{0, 0, 0, 1, 1, 16'h7FFF, 1, 0, SG ? 16'h7FFF : 16'h8001,
                   SG ? 16'h8000 : 16'h7FFE, SG ? 16'hFFFF : 16'h0003, 5, 4'h0, 0});
    vq.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{1, 0, 1, 0, 1, 16'h0100, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{2, 0, 1, 0, 1, 16'h0500, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{1, 1, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{2, 1, 0, 0, 1, 16'h0600, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{1, 0, 0, 1, 1, 16'hFFFF, 1, 1, SG ? 16'h0100 : 16'hFFFF,
                   SG ? 16'hFFFF : 16'h0000, SG ? 16'h0101 : 16'hFFFF, 3, 4'h0, 0});
    vq.push_back('{2, 0, 0, 1, 1, 16'h0550, 1, 2, 16'h0600, 16'h0500, 16'h0100, 3, 4'h0, 0});
    vq.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{3, 0, 0, 1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 4'h8, 0});
    vq.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 4'h8, 0});
    vq.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 4'h8, 0});
    vq.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 4'h8, 0});
    vq.push_back('{3, 0, 1, 0, 1, 16'h0010, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{0, 0, 1, 0, 1, 16'h0005, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{0, 0, 1, 1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 4'h1, 0});
    vq.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 4'h1, 0});
    vq.push_back('{0, 0, 1, 0, 1, 16'h0001, 0, 0, 0, 0, 0, 0, 4'h0, 0});
    vq.push_back('{0, 0, 0, 1, 0, 16'h0002, 1, 0, 16'h0002, 16'h0001, 16'h0001, 2, 4'h0, 0});
    vq.push_back('{1, 0, 1, 0, 0, 16'h0009, 1, 0, 16'h0002, 16'h0001, 16'h0001, 2, 4'h0, 0});
    vq.push_back('{1, 0, 0, 1, 0, 16'h0003, 1, 0, 16'h0002, 16'h0001, 16'h0001, 2, 4'h0, 1});
    vq.push_back('{2, 0, 1, 0, 0, 16'h0007, 1, 0, 16'h0002, 16'h0001, 16'h0001, 2, 4'h0, 1});
    vq.push_back('{2, 0, 0, 1, 1, 16'h0008, 1, 2, 16'h0008, 16'h0007, 16'h0001, 2, 4'h0, 1});
    vq.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 4'h0, 1});
    vq.push_back('{3, 0, 0, 1, 1, 16'h0020, 1, 3, 16'h0020, 16'h0010, 16'h0010, 2, 4'h0, 1});
    vq.push_back('{1, 1, 0, 0, 1, 16'h1234, 0, 0, 0, 0, 0, 0, 4'h0, 1});
    vq.push_back('{1, 0, 0, 1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 4'h2, 1});

    repeat (2) @(negedge clock);
    chk("reset valid", res_valid, 0);
    chk("reset max", res_max, 0);
    chk("reset count", res_count, 0);
    chk("reset err", debug_error, 0);
    chk("reset ovf", overflow, 0);
    reset = 0;
    @(negedge clock);

    foreach (vq[i]) begin
      drv(vq[i].ch, vq[i].sv, vq[i].g, vq[i].f, vq[i].rdy, vq[i].d);
      chk($sformatf("r%0d valid", i), res_valid, vq[i].ev);
      chk($sformatf("r%0d err", i), debug_error, vq[i].eerr);
      chk($sformatf("r%0d ovf", i), overflow, vq[i].eovf);
      if (vq[i].ev) begin
        chk($sformatf("r%0d chan", i), res_chan, vq[i].ech);
        chk($sformatf("r%0d max", i), res_max, vq[i].emax);
        chk($sformatf("r%0d min", i), res_min, vq[i].emin);
        chk($sformatf("r%0d range", i), res_range, vq[i].erng);
        chk($sformatf("r%0d count", i), res_count, vq[i].ecnt);
      end
    end

    drv(0, 0, 1, 0, 1, 16'h0001);
    drv(0, 1, 0, 0, 1, 16'hFFFF);
    drv(0, 0, 0, 1, 1, 16'h0000);
    chk("sgn valid", res_valid, 1);
    chk("sgn max", res_max, SG ? 16'h0001 : 16'hFFFF);
    chk("sgn min", res_min, SG ? 16'hFFFF : 16'h0000);
    chk("sgn range", res_range, SG ? 16'h0002 : 16'hFFFF);
    chk("sgn count", res_count, 3);

    drv3(1, 0, 1, 0, 16'h0003);
    for (int k = 0; k < 9; k++) drv3(1, 1, 0, 0, 16'(k));
    drv3(1, 0, 0, 1, 16'h0004);
    chk("sat valid", v3, 1);
    chk("sat count", cnt3, 7);
    chk("sat max", max3, 16'h0008);
    chk("sat range", rng3, 16'h0008);
    drv3(3, 0, 0, 1, 16'h0000);
    chk("badchan err", err3, 0);
    chk("badchan valid", v3, 0);

    drv(1, 0, 1, 0, 1, 16'h0042);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("rst ovf", overflow, 0);
    chk("rst err", debug_error, 0);
    drv(1, 0, 0, 1, 1, 16'h0043);
    chk("rst no result", res_valid, 0);
    chk("rst finish err", debug_error, 4'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
